mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge system clock.
REQ-002 SHALL have port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL have port: op_code  input  6  opcode field of the instruction register.
REQ-004 SHALL have port: mem_ready  input  1  memory handshake; high = current memory access completes this cycle.
REQ-005 SHALL have ports, all outputs width 1: pc_write, branch, branch_ne, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a.
REQ-006 SHALL have ports: alu_src_b  output  2  (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2); alu_op  output  2  ALU control selector (00 add, 01 sub, 10 funct, 11 op_code); pc_src  output  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-007 SHALL have ports: illegal_op  output  1  one-cycle pulse on unsupported opcode; state  output  4  current state encoding, for debug.

Function
REQ-008 SHALL be a Moore FSM; every output is a pure decode of the state register plus mem_ready gating per REQ-010.
REQ-009 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, ALU_WB 7, BRANCH 8, IMM_EX 9, JUMP 10; codes 11-15 SHALL go to FETCH on the next clock.
REQ-010 FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_write=mem_ready; hold in FETCH while mem_ready=0, go to DECODE when mem_ready=1.
REQ-011 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state: lw/sw (100011/101011) MEMADR, R-type (000000) RTYPE_EX, beq (000100) BRANCH, addi/andi/ori/slti (001000/001100/001101/001010) IMM_EX, j (000010) JUMP. Any other opcode goes to FETCH with illegal_op=1 for this cycle.
REQ-012 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for lw, MEMWR for sw.
REQ-013 MEMRD: iord=1; hold while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-014 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; then FETCH.
REQ-015 MEMWR: iord=1, mem_write=1; hold while mem_ready=0; go to FETCH when mem_ready=1.
REQ-016 RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10; then ALU_WB.
REQ-017 ALU_WB: reg_write=1, mem_to_reg=0; reg_dst=1 when entered from RTYPE_EX, 0 when entered from IMM_EX (one internal flag register); then FETCH.
REQ-018 IMM_EX: alu_src_a=1, alu_src_b=10; alu_op=00 for addi, 11 for andi/ori/slti; then ALU_WB.
REQ-019 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1; then FETCH.
REQ-020 JUMP: pc_src=10, pc_write=1; then FETCH.
REQ-021 Outputs not listed for a state SHALL be 0; alu_op, alu_src_b and pc_src SHALL be 00.
REQ-022 The controller SHALL sample op_code only in DECODE and IMM_EX; op_code changes in other states SHALL have no effect.

Reset
REQ-023 rst_n low SHALL force state to FETCH immediately, asynchronously, including mid-access in MEMRD or MEMWR; the ALU_WB flag SHALL clear to 0.
REQ-024 During reset, outputs SHALL equal the FETCH decode, with ir_write and pc_write following mem_ready; illegal_op SHALL be 0.
REQ-025 On the first rising clk after rst_n deasserts, the FSM SHALL evaluate FETCH transitions normally.

Configuration
REQ-026 Macro MC_CONTROL_BNE_EN defined: DECODE SHALL route op 000101 (bne) to BRANCH, and BRANCH SHALL assert branch_ne=1, branch=0 for bne; beq keeps branch=1, branch_ne=0.
REQ-027 Macro MC_CONTROL_BNE_EN undefined: bne SHALL be illegal per REQ-011, and branch_ne SHALL be tied to 0.

Verification
REQ-028 Reset, then lw (100011) with mem_ready=1 every cycle -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-029 sw with mem_ready held 0 for 3 cycles in MEMWR -> mem_write=1 and iord=1 for 4 cycles, then FETCH.
REQ-030 R-type op 000000 -> alu_op=10 in RTYPE_EX; ALU_WB has reg_dst=1. ori 001101 -> alu_op=11 in IMM_EX; ALU_WB has reg_dst=0.
REQ-031 beq -> BRANCH with alu_op=01, pc_src=01, branch=1. j -> pc_write=1, pc_src=10. Opcode 111111 -> illegal_op pulses 1 cycle, then FETCH.
REQ-032 rst_n pulsed low mid-MEMRD -> state=0 without a clock edge; no reg_write is asserted afterward until a new instruction sequence.
REQ-033 bne 000101 run in both macro builds -> defined: BRANCH with branch_ne=1; undefined: illegal_op=1 and return to FETCH.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle datapath controller (Moore FSM); define MC_CONTROL_BNE_EN to add bne support
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_code,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, ALU_WB, BRANCH, IMM_EX, JUMP
  } state_t;
  state_t cur;
  logic rd_flag, sw_flag, bne_flag;
  logic is_mem, is_r, is_beq, is_bne, is_imm, is_j, legal;
  assign is_mem = op_code == 6'b100011 || op_code == 6'b101011;
  assign is_r   = op_code == 6'b000000;
  assign is_beq = op_code == 6'b000100;
  assign is_imm = op_code == 6'b001000 || op_code == 6'b001100 ||
                  op_code == 6'b001101 || op_code == 6'b001010;
  assign is_j   = op_code == 6'b000010;
  assign legal  = is_mem | is_r | is_beq | is_bne | is_imm | is_j;
`ifdef MC_CONTROL_BNE_EN
  assign is_bne = op_code == 6'b000101;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bne_flag <= 1'b0;
    else if (cur == DECODE) bne_flag <= is_bne;
`else
  assign is_bne   = 1'b0;
  assign bne_flag = 1'b0;
`endif
  // opcode is only looked at in DECODE/IMM_EX; what later states need is latched here
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur     <= FETCH;
      rd_flag <= 1'b0;
      sw_flag <= 1'b0;
    end else begin
      case (cur)
        FETCH:    cur <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          sw_flag <= op_code == 6'b101011;
          cur     <= is_mem ? MEMADR : is_r ? RTYPE_EX : (is_beq | is_bne) ? BRANCH :
                     is_imm ? IMM_EX : is_j ? JUMP : FETCH;
        end
        MEMADR:   cur <= sw_flag ? MEMWR : MEMRD;
        MEMRD:    cur <= mem_ready ? MEMWB : MEMRD;
        MEMWR:    cur <= mem_ready ? FETCH : MEMWR;
        RTYPE_EX: begin
          cur     <= ALU_WB;
          rd_flag <= 1'b1;
        end
        IMM_EX:   begin
          cur     <= ALU_WB;
          rd_flag <= 1'b0;
        end
        default:  cur <= FETCH;
      endcase
    end
  always_comb begin
    {pc_write, branch, branch_ne, iord, mem_write, ir_write, reg_dst, mem_to_reg,
     reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op} = '0;
    case (cur)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !legal;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD:  iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = rd_flag;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = !bne_flag;
        branch_ne = bne_flag;
      end
      IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = op_code == 6'b001000 ? 2'b00 : 2'b11;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end
  assign state = cur;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: instruction-level expectation queue checked every cycle, plus literal spot checks
module tb_mc_control_fsm;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] op_code = 6'd0;
  logic pc_write, branch, branch_ne, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [20:0] got, e;
  logic [20:0] q[$];
  int total = 0, bad = 0, mw_cnt = 0, il_cnt = 0, bn_cnt = 0, snap;

  mc_control_fsm dut (.clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal_op(illegal_op), .state(state));

  always #5 clk = ~clk;
  assign got = {pc_write, branch, branch_ne, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, state};

  task automatic chk(string nm, logic [20:0] g, logic [20:0] x);
    total++;
    if (g !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, g, x, $time);
    end
  endtask

  // expected outputs for one cycle, straight from the per-state output table
  function automatic logic [20:0] row(int st, bit mr = 0, bit dst = 0, bit addi = 0, bit ill = 0, bit bne = 0);
    logic pcw, br, brn, io, mw, irw, rd, m2r, rw, sa;
    logic [1:0] sb, ao, ps;
    {pcw, br, brn, io, mw, irw, rd, m2r, rw, sa, sb, ao, ps} = '0;
    case (st)
      0: begin sb = 2'b01; irw = mr; pcw = mr; end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: io = 1;
      4: begin m2r = 1; rw = 1; end
      5: begin io = 1; mw = 1; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rd = dst; end
      8: begin sa = 1; ao = 2'b01; ps = 2'b01; br = !bne; brn = bne; end
      9: begin sa = 1; sb = 2'b10; ao = addi ? 2'b00 : 2'b11; end
      10: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, br, brn, io, mw, irw, rd, m2r, rw, sa, sb, ao, ps, ill, 4'(st)};
  endfunction

  function automatic int kind(logic [5:0] op);
    case (op)
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000000: return 3;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return 4;
      6'b000100: return 5;
`ifdef MC_CONTROL_BNE_EN
      6'b000101: return 5;
`endif
      6'b000010: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction
  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(logic [5:0] op, logic mr, logic [20:0] x);
    @(posedge clk);
    #1;
    op_code = op;
    mem_ready = mr;
    q.push_back(x);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // one instruction: fetch (with fw wait cycles), decode, then the execution path for its class
  task automatic run(logic [5:0] op, int fw, int mw);
    for (int i = 0; i < fw; i++) step(rop(), 1'b0, row(0));
    step(rop(), 1'b1, row(0, 1));
    step(op, rbit(), row(1, 0, 0, 0, kind(op) == 0));
    case (kind(op))
      1: begin
        step(rop(), rbit(), row(2));
        for (int i = 0; i < mw; i++) step(rop(), 1'b0, row(3));
        step(rop(), 1'b1, row(3));
        step(rop(), rbit(), row(4));
      end
      2: begin
        step(rop(), rbit(), row(2));
        for (int i = 0; i < mw; i++) step(rop(), 1'b0, row(5));
        step(rop(), 1'b1, row(5));
      end
      3: begin
        step(rop(), rbit(), row(6));
        step(rop(), rbit(), row(7, 0, 1));
      end
      4: begin
        step(op, rbit(), row(9, 0, 0, op == 6'b001000));
        step(rop(), rbit(), row(7, 0, 0));
      end
      5: step(rop(), rbit(), row(8, 0, 0, 0, 0, op == 6'b000101));
      6: step(rop(), rbit(), row(10));
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mw_cnt += int'(mem_write);
      il_cnt += int'(illegal_op);
      bn_cnt += int'(branch_ne);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("cycle", got, e);
    end
  end

  initial begin
    #3;
    chk("rst_state", 21'(state), 21'd0);
    chk("rst_irw_lo", 21'(ir_write), 21'd0);
    chk("rst_srcb", 21'(alu_src_b), 21'd1);
    chk("rst_illegal", 21'(illegal_op), 21'd0);
    mem_ready = 1'b1;
    #1;
    chk("rst_irw_hi", 21'({ir_write, pc_write}), 21'd3);
    chk("rst_row", got, row(0, 1));
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(6'b100011, 0, 0);
    snap = mw_cnt;
    run(6'b101011, 1, 3);
    settle();
    chk("sw_write_cycles", 21'(mw_cnt - snap), 21'd4);
    run(6'b000000, 0, 0);
    run(6'b001101, 2, 0);
    run(6'b001000, 0, 0);
    run(6'b001100, 0, 0);
    run(6'b001010, 0, 0);
    run(6'b000100, 0, 0);
    run(6'b000010, 0, 0);
    snap = il_cnt;
    run(6'b111111, 0, 0);
    settle();
    chk("illegal_pulse", 21'(il_cnt - snap), 21'd1);
    snap = il_cnt;
    bn_cnt = 0;
    run(6'b000101, 0, 0);
    settle();
`ifdef MC_CONTROL_BNE_EN
    chk("bne_illegal", 21'(il_cnt - snap), 21'd0);
    chk("bne_branch_ne", 21'(bn_cnt), 21'd1);
`else
    chk("bne_illegal", 21'(il_cnt - snap), 21'd1);
    chk("bne_branch_ne", 21'(bn_cnt), 21'd0);
`endif
    run(6'b100011, 1, 2);
    // reset in the middle of a memory read, with no clock edge involved
    step(rop(), 1'b1, row(0, 1));
    step(6'b100011, rbit(), row(1));
    step(rop(), rbit(), row(2));
    step(rop(), 1'b0, row(3));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrd_state", 21'(state), 21'd0);
    chk("midrd_regw", 21'(reg_write), 21'd0);
    chk("midrd_iord", 21'(iord), 21'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(rop(), 1'b0, row(0));
    run(6'b100011, 0, 1);
    settle();
    chk("queue_drained", 21'(q.size()), 21'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
